extract_in_arb: RTL and testbench

EXTRACT_IN_ARB -- requirements
Module: extract_in_arb

---
 rtl/extract_in_arb.sv | 205 ++++++++++++++++++++
 tb/tb_extract_in_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/extract_in_arb.sv
// ---------------------------------------------------------------------------
// extract_in_arb
//
// Two-source packet arbiter in front of the Extract block. Whole packets
// from source 0 or source 1 are forwarded onto a single streaming output;
// once a source wins, it owns the output until its end-of-packet beat
// transfers. Ties between two start-of-packet beats are settled by
// round-robin. Beats that show up while idle without start-of-packet are
// orphans: they are accepted and discarded so a source cannot wedge the
// arbiter.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   inN_valid/_ready         source N handshake (readyLatency 0), N=0,1
//   inN_startofpacket/_endofpacket/_error/_data/_empty
//                            source N beat payload
//   out_valid/_ready         sink handshake (readyLatency 0)
//   out_startofpacket/_endofpacket/_error/_data/_empty
//                            forwarded beat payload
//   grant                    one-hot owner (01 src0, 10 src1, 00 idle)
//   pkt_cnt0/pkt_cnt1        saturating packets-forwarded counters
//   drop_cnt                 saturating orphan-beat counter
//   proto_err                sticky: sop seen on a non-first beat
// ---------------------------------------------------------------------------
module extract_in_arb #(
   parameter int DATA_WIDTH  = 64,
   parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8),
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,

   input  logic                   in0_valid,
   input  logic                   in0_startofpacket,
   input  logic                   in0_endofpacket,
   input  logic                   in0_error,
   input  logic [DATA_WIDTH-1:0]  in0_data,
   input  logic [EMPTY_WIDTH-1:0] in0_empty,
   output logic                   in0_ready,

   input  logic                   in1_valid,
   input  logic                   in1_startofpacket,
   input  logic                   in1_endofpacket,
   input  logic                   in1_error,
   input  logic [DATA_WIDTH-1:0]  in1_data,
   input  logic [EMPTY_WIDTH-1:0] in1_empty,
   output logic                   in1_ready,

   output logic                   out_valid,
   output logic                   out_startofpacket,
   output logic                   out_endofpacket,
   output logic                   out_error,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [EMPTY_WIDTH-1:0] out_empty,
   input  logic                   out_ready,

   output logic [1:0]             grant,
   output logic [CNT_WIDTH-1:0]   pkt_cnt0,
   output logic [CNT_WIDTH-1:0]   pkt_cnt1,
   output logic [CNT_WIDTH-1:0]   drop_cnt,
   output logic                   proto_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t                 state_q;
   logic [1:0]             grant_q;
   logic                   last_q;      // 1: source 1 was granted last
   logic                   first_q;     // next transfer is the packet's first beat
   logic                   active_q;    // low for the first cycle after reset
   logic [CNT_WIDTH-1:0]   pkt_cnt0_q, pkt_cnt1_q, drop_cnt_q;
   logic                   proto_err_q;

   logic                   cand0, cand1;
   logic                   lock_xfer;
   logic [1:0]             drop_inc;

   // Saturating add of 0..2; the extra sum bit flags overflow.
   function automatic logic [CNT_WIDTH-1:0] sat_add(
      input logic [CNT_WIDTH-1:0] a,
      input logic [1:0]           inc
   );
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
      return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction

   assign cand0 = in0_valid & in0_startofpacket;
   assign cand1 = in1_valid & in1_startofpacket;

   // ------------------------------------------------------------------
   // Datapath and handshakes. In LOCKn the owner is wired straight
   // through; in IDLE only orphan beats are acked. active_q keeps every
   // ready low while reset is asserted, since an orphan ack would
   // otherwise be a combinational function of the inputs alone.
   // ------------------------------------------------------------------
   always_comb begin
      in0_ready         = 1'b0;
      in1_ready         = 1'b0;
      out_valid         = 1'b0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      out_error         = 1'b0;
      out_data          = '0;
      out_empty         = '0;
      unique case (state_q)
         IDLE: begin
            in0_ready = active_q & in0_valid & ~in0_startofpacket;
            in1_ready = active_q & in1_valid & ~in1_startofpacket;
         end
         LOCK0: begin
            out_valid         = in0_valid;
            out_startofpacket = in0_startofpacket;
            out_endofpacket   = in0_endofpacket;
            out_error         = in0_error;
            out_data          = in0_data;
            out_empty         = in0_empty;
            in0_ready         = out_ready;
         end
         LOCK1: begin
            out_valid         = in1_valid;
            out_startofpacket = in1_startofpacket;
            out_endofpacket   = in1_endofpacket;
            out_error         = in1_error;
            out_data          = in1_data;
            out_empty         = in1_empty;
            in1_ready         = out_ready;
         end
         default: ;
      endcase
   end

   // out_valid is only nonzero while locked, so this is the owner's transfer.
   assign lock_xfer = out_valid & out_ready;

   // Orphan beats transfer exactly when their IDLE ready is high.
   assign drop_inc = {1'b0, in0_valid & in0_ready & (state_q == IDLE)}
                   + {1'b0, in1_valid & in1_ready & (state_q == IDLE)};

   // ------------------------------------------------------------------
   // Arbitration FSM with registered grant and statistics.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         grant_q     <= 2'b00;
         last_q      <= 1'b1;
         first_q     <= 1'b0;
         active_q    <= 1'b0;
         pkt_cnt0_q  <= '0;
         pkt_cnt1_q  <= '0;
         drop_cnt_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
               // Source 0 wins alone, or on a tie when source 1 went last.
               if (cand0 && (!cand1 || last_q)) begin
                  state_q <= LOCK0;
                  grant_q <= 2'b01;
                  first_q <= 1'b1;
               end else if (cand1) begin
                  state_q <= LOCK1;
                  grant_q <= 2'b10;
                  first_q <= 1'b1;
               end
            end
            LOCK0, LOCK1: begin
               if (lock_xfer) begin
                  first_q <= 1'b0;
                  // A restart inside a packet is forwarded but remembered.
                  if (!first_q && out_startofpacket)
                     proto_err_q <= 1'b1;
                  if (out_endofpacket) begin
                     state_q <= IDLE;
                     grant_q <= 2'b00;
                     last_q  <= (state_q == LOCK1);
                     if (state_q == LOCK0)
                        pkt_cnt0_q <= sat_add(pkt_cnt0_q, 2'd1);
                     else
                        pkt_cnt1_q <= sat_add(pkt_cnt1_q, 2'd1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign pkt_cnt0  = pkt_cnt0_q;
   assign pkt_cnt1  = pkt_cnt1_q;
   assign drop_cnt  = drop_cnt_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_extract_in_arb.sv
// ---------------------------------------------------------------------------
// Directed bench for extract_in_arb. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, so registered state reflects the
// preceding rising edge. CNT_WIDTH=2 so counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_extract_in_arb;
   localparam int DW = 32;
   localparam int EW = 2;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in0_valid, in0_startofpacket, in0_endofpacket, in0_error, in0_ready;
   logic [DW-1:0] in0_data;
   logic [EW-1:0] in0_empty;
   logic          in1_valid, in1_startofpacket, in1_endofpacket, in1_error, in1_ready;
   logic [DW-1:0] in1_data;
   logic [EW-1:0] in1_empty;
   logic          out_valid, out_startofpacket, out_endofpacket, out_error, out_ready;
   logic [DW-1:0] out_data;
   logic [EW-1:0] out_empty;
   logic [1:0]    grant;
   logic [CW-1:0] pkt_cnt0, pkt_cnt1, drop_cnt;
   logic          proto_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   extract_in_arb #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in0_valid(in0_valid), .in0_startofpacket(in0_startofpacket),
      .in0_endofpacket(in0_endofpacket), .in0_error(in0_error),
      .in0_data(in0_data), .in0_empty(in0_empty), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_startofpacket(in1_startofpacket),
      .in1_endofpacket(in1_endofpacket), .in1_error(in1_error),
      .in1_data(in1_data), .in1_empty(in1_empty), .in1_ready(in1_ready),
      .out_valid(out_valid), .out_startofpacket(out_startofpacket),
      .out_endofpacket(out_endofpacket), .out_error(out_error),
      .out_data(out_data), .out_empty(out_empty), .out_ready(out_ready),
      .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
      .drop_cnt(drop_cnt), .proto_err(proto_err)
   );

   task automatic clr_in();
      in0_valid = 0; in0_startofpacket = 0; in0_endofpacket = 0; in0_error = 0;
      in0_data = '0; in0_empty = '0;
      in1_valid = 0; in1_startofpacket = 0; in1_endofpacket = 0; in1_error = 0;
      in1_data = '0; in1_empty = '0;
      out_ready = 1;
   endtask

   task automatic do_reset();
      @(negedge clk); reset_n = 0; clr_in();
      @(negedge clk); reset_n = 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 0; clr_in();
      in0_valid = 1; in1_valid = 1; in1_startofpacket = 1;
      #1;
      tests++; if (in0_ready !== 1'b0) begin fails++; $display("FAIL rst_in0_ready got %0b exp 0", in0_ready); end
      tests++; if (in1_ready !== 1'b0) begin fails++; $display("FAIL rst_in1_ready got %0b exp 0", in1_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rst_grant got %0b exp 00", grant); end
      tests++; if ({pkt_cnt0, pkt_cnt1, drop_cnt} !== '0) begin fails++; $display("FAIL rst_counters got %0h/%0h/%0h exp 0", pkt_cnt0, pkt_cnt1, drop_cnt); end
      tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL rst_proto_err got %0b exp 0", proto_err); end
      @(negedge clk); #1;
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rst_hold_grant got %0b exp 00", grant); end
      @(negedge clk); clr_in(); reset_n = 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [DW-1:0] exp_d;
      @(negedge clk);
      in0_valid = 1; in0_startofpacket = 1; in0_data = 32'hA0;
      #1;
      tests++; if (in0_ready !== 1'b0) begin fails++; $display("FAIL single_bubble_ready got %0b exp 0", in0_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_idle_valid got %0b exp 0", out_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_d = 32'hA0 + DW'(i);
         in0_data = exp_d; in0_startofpacket = (i == 0); in0_endofpacket = (i == 2);
         in0_error = (i == 1); in0_empty = (i == 2) ? 2'd3 : 2'd0;
         #1;
         tests++; if (grant !== 2'b01) begin fails++; $display("FAIL single_grant[%0d] got %0b exp 01", i, grant); end
         tests++; if ({out_valid, out_startofpacket, out_endofpacket, out_error} !== {1'b1, i == 0, i == 2, i == 1})
            begin fails++; $display("FAIL single_strobes[%0d] got %b", i, {out_valid, out_startofpacket, out_endofpacket, out_error}); end
         tests++; if (out_data !== exp_d) begin fails++; $display("FAIL single_data[%0d] got %0h exp %0h", i, out_data, exp_d); end
         tests++; if ({in0_ready, in1_ready} !== 2'b10) begin fails++; $display("FAIL single_ready[%0d] got %b exp 10", i, {in0_ready, in1_ready}); end
      end
      tests++; if (out_empty !== 2'd3) begin fails++; $display("FAIL single_empty got %0d exp 3", out_empty); end
      @(negedge clk); clr_in(); #1;
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL single_end_grant got %0b exp 00", grant); end
      tests++; if (pkt_cnt0 !== 2'd1) begin fails++; $display("FAIL single_pkt_cnt0 got %0d exp 1", pkt_cnt0); end
      tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL single_proto_err got %0b exp 0", proto_err); end
   endtask

   task automatic tie_round(input int r);
      @(negedge clk);
      in0_valid = 1; in0_startofpacket = 1; in0_endofpacket = 1; in0_data = 32'h100 + DW'(r);
      in1_valid = 1; in1_startofpacket = 1; in1_endofpacket = 1; in1_data = 32'h200 + DW'(r);
      #1;
      tests++; if ({grant, in0_ready, in1_ready} !== 4'b0000) begin fails++; $display("FAIL tie%0d_idle got %b exp 0000", r, {grant, in0_ready, in1_ready}); end
      @(negedge clk); #1;
      tests++; if (grant !== 2'b01) begin fails++; $display("FAIL tie%0d_first got %0b exp 01", r, grant); end
      tests++; if (out_data !== 32'h100 + DW'(r)) begin fails++; $display("FAIL tie%0d_data0 got %0h exp %0h", r, out_data, 32'h100 + r); end
      tests++; if (in1_ready !== 1'b0) begin fails++; $display("FAIL tie%0d_in1_held got %0b exp 0", r, in1_ready); end
      @(negedge clk); in0_valid = 0; #1;
      tests++; if ({grant, out_valid} !== 3'b000) begin fails++; $display("FAIL tie%0d_gap got %b exp 000", r, {grant, out_valid}); end
      @(negedge clk); #1;
      tests++; if (grant !== 2'b10) begin fails++; $display("FAIL tie%0d_second got %0b exp 10", r, grant); end
      tests++; if (out_data !== 32'h200 + DW'(r)) begin fails++; $display("FAIL tie%0d_data1 got %0h exp %0h", r, out_data, 32'h200 + r); end
      @(negedge clk); in1_valid = 0; #1;
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL tie%0d_end got %0b exp 00", r, grant); end
   endtask

   task automatic test_tie();
      do_reset();
      tie_round(1);
      tie_round(2);
      tests++; if ({pkt_cnt0, pkt_cnt1} !== {2'd2, 2'd2}) begin fails++; $display("FAIL tie_counts got %0d/%0d exp 2/2", pkt_cnt0, pkt_cnt1); end
      // Source 0 goes last, so the next tie belongs to source 1.
      @(negedge clk);
      in0_valid = 1; in0_startofpacket = 1; in0_endofpacket = 1; in0_data = 32'h300;
      @(negedge clk);
      in1_valid = 1; in1_startofpacket = 1; in1_endofpacket = 1; in1_data = 32'h400;
      #1;
      tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rr_src0 got %0b exp 01", grant); end
      @(negedge clk); #1;
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rr_idle got %0b exp 00", grant); end
      @(negedge clk); #1;
      tests++; if (grant !== 2'b10) begin fails++; $display("FAIL rr_src1_wins got %0b exp 10", grant); end
      @(negedge clk); in1_valid = 0;
      @(negedge clk);
      @(negedge clk); clr_in();
   endtask

   task automatic test_orphan();
      do_reset();
      @(negedge clk); in1_valid = 1; in1_data = 32'hDEAD; #1;
      tests++; if ({in1_ready, out_valid, grant} !== 4'b1000) begin fails++; $display("FAIL orphan_ack got %b exp 1000", {in1_ready, out_valid, grant}); end
      @(negedge clk); in1_data = 32'hBEEF; #1;
      tests++; if (drop_cnt !== 2'd1) begin fails++; $display("FAIL orphan_drop1 got %0d exp 1", drop_cnt); end
      tests++; if (in1_ready !== 1'b1) begin fails++; $display("FAIL orphan_ack2 got %0b exp 1", in1_ready); end
      @(negedge clk); in1_valid = 0; #1;
      tests++; if (drop_cnt !== 2'd2) begin fails++; $display("FAIL orphan_drop2 got %0d exp 2", drop_cnt); end
      tests++; if ({grant, pkt_cnt1} !== 4'b0000) begin fails++; $display("FAIL orphan_nolock got %b exp 0000", {grant, pkt_cnt1}); end
      @(negedge clk); in0_valid = 1; in1_valid = 1; #1;
      tests++; if ({in0_ready, in1_ready} !== 2'b11) begin fails++; $display("FAIL orphan_both_ack got %b exp 11", {in0_ready, in1_ready}); end
      @(negedge clk); clr_in(); #1;
      tests++; if (drop_cnt !== 2'd3) begin fails++; $display("FAIL orphan_sat got %0d exp 3", drop_cnt); end
   endtask

   task automatic test_backpressure();
      logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int beat = 0;
      do_reset();
      @(negedge clk);
      in0_valid = 1; in0_startofpacket = 1; in0_data = 32'hB0;
      in1_valid = 1; in1_startofpacket = 1; in1_endofpacket = 1; in1_data = 32'hC0;
      #1;
      tests++; if ({grant, in0_ready} !== 3'b000) begin fails++; $display("FAIL bp_idle got %b exp 000", {grant, in0_ready}); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in0_data = 32'hB0 + DW'(beat);
         in0_startofpacket = (beat == 0); in0_endofpacket = (beat == 3);
         out_ready = pat[c];
         #1;
         tests++; if (out_data !== 32'hB0 + DW'(beat)) begin fails++; $display("FAIL bp_data[%0d] got %0h exp %0h", c, out_data, 32'hB0 + beat); end
         tests++; if ({grant, in0_ready, in1_ready} !== {2'b01, pat[c], 1'b0}) begin fails++; $display("FAIL bp_hs[%0d] got %b exp %b", c, {grant, in0_ready, in1_ready}, {2'b01, pat[c], 1'b0}); end
         tests++; if (pkt_cnt0 !== 2'd0) begin fails++; $display("FAIL bp_cnt[%0d] got %0d exp 0", c, pkt_cnt0); end
         if (pat[c]) beat++;
      end
      @(negedge clk); in0_valid = 0; out_ready = 1; #1;
      tests++; if ({grant, pkt_cnt0} !== {2'b00, 2'd1}) begin fails++; $display("FAIL bp_done got %b exp 0001", {grant, pkt_cnt0}); end
      @(negedge clk); #1;
      tests++; if ({grant, out_data} !== {2'b10, 32'hC0}) begin fails++; $display("FAIL bp_in1 got %0b/%0h exp 10/c0", grant, out_data); end
      @(negedge clk); clr_in(); #1;
      tests++; if (pkt_cnt1 !== 2'd1) begin fails++; $display("FAIL bp_pkt_cnt1 got %0d exp 1", pkt_cnt1); end
   endtask

   task automatic test_violation_reset();
      do_reset();
      @(negedge clk); in0_valid = 1; in0_startofpacket = 1; in0_data = 32'hE0;
      @(negedge clk); #1;
      tests++; if ({grant, out_startofpacket, proto_err} !== 4'b0110) begin fails++; $display("FAIL viol_first got %b exp 0110", {grant, out_startofpacket, proto_err}); end
      @(negedge clk); in0_data = 32'hE1; #1;
      tests++; if ({out_startofpacket, out_data} !== {1'b1, 32'hE1}) begin fails++; $display("FAIL viol_fwd got %0b/%0h exp 1/e1", out_startofpacket, out_data); end
      tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL viol_early got %0b exp 0", proto_err); end
      @(negedge clk); in0_startofpacket = 0; in0_data = 32'hE2; #1;
      tests++; if ({grant, proto_err} !== 3'b011) begin fails++; $display("FAIL viol_flag got %b exp 011", {grant, proto_err}); end
      @(negedge clk); reset_n = 0; #1;
      tests++; if ({grant, proto_err, out_valid, in0_ready} !== 5'b00000) begin fails++; $display("FAIL viol_rst got %b exp 00000", {grant, proto_err, out_valid, in0_ready}); end
      tests++; if ({pkt_cnt0, drop_cnt} !== '0) begin fails++; $display("FAIL viol_rst_cnt got %0d/%0d exp 0/0", pkt_cnt0, drop_cnt); end
      @(negedge clk); reset_n = 1; in0_data = 32'hE3;
      @(negedge clk); #1;
      tests++; if ({in0_ready, out_valid, grant} !== 4'b1000) begin fails++; $display("FAIL viol_orphan got %b exp 1000", {in0_ready, out_valid, grant}); end
      @(negedge clk); clr_in(); #1;
      tests++; if ({drop_cnt, pkt_cnt0} !== {2'd1, 2'd0}) begin fails++; $display("FAIL viol_drop got %0d/%0d exp 1/0", drop_cnt, pkt_cnt0); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in0_valid = 1; in0_startofpacket = 1; in0_endofpacket = 1; in0_data = 32'hF0 + DW'(k);
         #1;
         tests++; if (grant !== ((k % 2 == 1) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL sat_grant[%0d] got %0b", k, grant); end
         if (k == 4) begin
            tests++; if (pkt_cnt0 !== 2'd2) begin fails++; $display("FAIL sat_cnt_mid got %0d exp 2", pkt_cnt0); end
         end
         if (k == 8) begin
            tests++; if (pkt_cnt0 !== 2'd3) begin fails++; $display("FAIL sat_cnt_4 got %0d exp 3", pkt_cnt0); end
         end
      end
      @(negedge clk); clr_in(); #1;
      tests++; if ({grant, pkt_cnt0} !== {2'b00, 2'd3}) begin fails++; $display("FAIL sat_final got %0b/%0d exp 00/3", grant, pkt_cnt0); end
   endtask

   initial begin
      clr_in();
      test_reset();
      test_single();
      test_tie();
      test_orphan();
      test_backpressure();
      test_violation_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
